// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for eight requesters with a decoder-style one-hot grant.
// The winner holds the resource until release, a request drop, en low or MAX_HOLD cycles.
module decoder_rr_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [2:0]        ptr, ptr_nxt;
  logic [2:0]        gnt_idx_nxt;
  logic              gnt_valid_nxt;
  logic              timeout_nxt;
  logic [7:0]        gnt_nxt;

  logic              pick_found;
  logic [2:0]        pick_idx;
  logic              rel_en, rel_own, rel_hold;

  // Search starts one past the last owner, so that owner is served last.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    for (int k = 1; k <= 8; k++) begin
      idx = p + 3'(k);
      if (r[idx] && !res[3]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [7:0] dec3to8(input logic [2:0] a, input logic e);
    return e ? (8'h01 << a) : 8'h00;
  endfunction

  assign {pick_found, pick_idx} = rr_pick(req, ptr);

  assign rel_en   = !en;
  assign rel_own  = done || !req[gnt_idx];
  assign rel_hold = (hold_cnt == HOLD_LAST);

  always_comb begin
    state_nxt     = state;
    hold_nxt      = hold_cnt;
    ptr_nxt       = ptr;
    gnt_idx_nxt   = gnt_idx;
    gnt_valid_nxt = gnt_valid;
    timeout_nxt   = 1'b0;
    case (state)
      IDLE: begin
        gnt_valid_nxt = 1'b0;
        if (en && pick_found) begin
          state_nxt     = GRANT;
          gnt_idx_nxt   = pick_idx;
          ptr_nxt       = pick_idx;
          gnt_valid_nxt = 1'b1;
          hold_nxt      = '0;
        end
      end
      GRANT: begin
        if (rel_en || rel_own || rel_hold) begin
          state_nxt     = IDLE;
          gnt_valid_nxt = 1'b0;
          // Pulse only when the hold limit is the sole reason for release.
          timeout_nxt   = !rel_en && !rel_own;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt     = IDLE;
        gnt_valid_nxt = 1'b0;
      end
    endcase
    gnt_nxt = dec3to8(gnt_idx_nxt, gnt_valid_nxt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      ptr       <= 3'd7;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
      gnt       <= 8'h00;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      ptr       <= ptr_nxt;
      gnt_idx   <= gnt_idx_nxt;
      gnt_valid <= gnt_valid_nxt;
      gnt       <= gnt_nxt;
      timeout   <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed bench for decoder_rr_arbiter: reset, rotation, wrap, timeout, release and enable cases.
module tb_decoder_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_vec = 0;
  int n_err = 0;

  decoder_rr_arbiter #(.MAX_HOLD(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] e_gnt, input logic [2:0] e_idx,
                           input logic e_vld, input logic e_to);
    check({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
    check({tag, ".idx"}, 32'(gnt_idx), 32'(e_idx));
    check({tag, ".vld"}, 32'(gnt_valid), 32'(e_vld));
    check({tag, ".to"}, 32'(timeout), 32'(e_to));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_gnt;
    rst_n = 1'b0; en = 1'b0; req = 8'h00; done = 1'b0;
    tick(); tick();
    check_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);

    // first grant after reset goes to requester 0
    rst_n = 1'b1; en = 1'b1; req = 8'h01;
    tick();
    check_out("first_grant", 8'h01, 3'd0, 1'b1, 1'b0);
    tick();
    check_out("hold", 8'h01, 3'd0, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    check_out("mid_reset", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1; req = 8'h00;
    tick();

    // full rotation 0..7,0 with done after each grant
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      tick();
      exp_gnt = 8'h01 << (i % 8);
      check_out($sformatf("rot%0d", i), exp_gnt, 3'(i % 8), 1'b1, 1'b0);
      done = 1'b1;
      tick();
      check_out($sformatf("rot%0d_rel", i), 8'h00, 3'(i % 8), 1'b0, 1'b0);
      done = 1'b0;
    end
    req = 8'h00;

    // make requester 6 the last owner, then check wrap 7 -> 0
    tick();
    req = 8'h40;
    tick();
    check_out("own6", 8'h40, 3'd6, 1'b1, 1'b0);
    req = 8'h00;
    tick();
    check_out("own6_drop", 8'h00, 3'd6, 1'b0, 1'b0);
    req = 8'h81;
    tick();
    check_out("wrap7", 8'h80, 3'd7, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    check_out("wrap0", 8'h01, 3'd0, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0; req = 8'h00;

    // timeout: owner 0 holds 16 cycles, then 2, then back to 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; req = 8'h05;
    tick();
    check_out("to_c1", 8'h01, 3'd0, 1'b1, 1'b0);
    for (int c = 2; c <= 16; c++) begin
      tick();
      check($sformatf("to_c%0d.vld", c), 32'(gnt_valid), 32'd1);
      check($sformatf("to_c%0d.to", c), 32'(timeout), 32'd0);
    end
    tick();
    check_out("to_pulse", 8'h00, 3'd0, 1'b0, 1'b1);
    tick();
    check_out("to_next2", 8'h04, 3'd2, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    check_out("to_rel2", 8'h00, 3'd2, 1'b0, 1'b0);
    done = 1'b0;
    tick();
    check_out("to_back0", 8'h01, 3'd0, 1'b1, 1'b0);
    req = 8'h00;
    tick();
    check_out("to_drop0", 8'h00, 3'd0, 1'b0, 1'b0);

    // other requesters changing is ignored; owner drop releases without timeout
    req = 8'h08;
    tick();
    check_out("own3", 8'h08, 3'd3, 1'b1, 1'b0);
    req = 8'hF8;
    tick();
    check_out("own3_others", 8'h08, 3'd3, 1'b1, 1'b0);
    req = 8'h00;
    tick();
    check_out("own3_drop", 8'h00, 3'd3, 1'b0, 1'b0);

    // done in idle is ignored
    done = 1'b1;
    tick();
    check_out("idle_done", 8'h00, 3'd3, 1'b0, 1'b0);
    done = 1'b0;

    // enable control
    req = 8'h02;
    tick();
    check_out("en_own1", 8'h02, 3'd1, 1'b1, 1'b0);
    en = 1'b0;
    tick();
    check_out("en_off", 8'h00, 3'd1, 1'b0, 1'b0);
    req = 8'hFF;
    tick();
    check_out("en_off_ff1", 8'h00, 3'd1, 1'b0, 1'b0);
    tick();
    check_out("en_off_ff2", 8'h00, 3'd1, 1'b0, 1'b0);
    en = 1'b1;
    tick();
    check_out("en_resume", 8'h04, 3'd2, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
